digi_screen: RTL and testbench

DIGI_SCREEN -- requirements
Module: digi_screen

---
 rtl/digi_screen.sv | 45 ++++
 tb/tb_digi_screen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/digi_screen.sv
// 8x8 red/green LED matrix scanner: drives one active-low row at a time with
// that row's red and green column bytes, holding each row for SCAN_DIV cycles.
module digi_screen #(
    parameter int SCAN_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PICTURE_R,
    input  logic [63:0] PICTURE_G,
    output logic [7:0]  n_row,
    output logic [7:0]  col_r,
    output logic [7:0]  col_g
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [2:0]  row_idx;
    logic [15:0] div_cnt;
    logic [5:0]  byte_lsb;

    // Row 0 lives in the top byte of each bitmap, row 7 in the bottom byte.
    assign byte_lsb = {3'd7 - row_idx, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_row   <= 8'hFF;
            col_r   <= 8'h00;
            col_g   <= 8'h00;
            row_idx <= 3'd0;
            div_cnt <= 16'd0;
        end else begin
            n_row <= ~(8'b1 << row_idx);
            col_r <= PICTURE_R[byte_lsb +: 8];
            col_g <= PICTURE_G[byte_lsb +: 8];
            // row_idx wraps 7->0 naturally, so frames run back to back.
            if (div_cnt == DIV_LAST) begin
                div_cnt <= 16'd0;
                row_idx <= row_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_digi_screen.sv
// Bench for digi_screen: two instances (SCAN_DIV=1 and 4) share stimulus;
// a reference model feeds expected-output queues drained by a monitor.
module tb_digi_screen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pic_r = 64'h0;
    logic [63:0] pic_g = 64'h0;
    logic [7:0]  n_row1, col_r1, col_g1;
    logic [7:0]  n_row4, col_r4, col_g4;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_q1[$];
    logic [23:0] exp_q4[$];
    int t1 = 0;
    int t4 = 0;

    always #5 clk = ~clk;

    digi_screen #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .PICTURE_R(pic_r), .PICTURE_G(pic_g),
        .n_row(n_row1), .col_r(col_r1), .col_g(col_g1)
    );

    digi_screen #(.SCAN_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .PICTURE_R(pic_r), .PICTURE_G(pic_g),
        .n_row(n_row4), .col_r(col_r4), .col_g(col_g4)
    );

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: t cycles into the scan, the row on display is (t / div) mod 8.
    function automatic logic [23:0] ref_out(input int t, input int div,
                                            input logic [63:0] pr, input logic [63:0] pg);
        int row;
        logic [7:0] sel;
        logic [7:0] rb;
        logic [7:0] gb;
        row = (t / div) % 8;
        sel = 8'h01 << row;
        rb  = 8'(pr >> (56 - 8 * row));
        gb  = 8'(pg >> (56 - 8 * row));
        return {~sel, rb, gb};
    endfunction

    // Model: one expected entry per edge, starting from the first reset edge.
    logic started = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1'b1;
            t1 = 0;
            t4 = 0;
            exp_q1.push_back(24'hFF0000);
            exp_q4.push_back(24'hFF0000);
        end else if (started) begin
            exp_q1.push_back(ref_out(t1, 1, pic_r, pic_g));
            exp_q4.push_back(ref_out(t4, 4, pic_r, pic_g));
            t1++;
            t4++;
        end
    end

    // Monitor: outputs change every edge, so every negedge presents one result.
    always @(negedge clk) begin
        if (exp_q1.size() > 0)
            check("scan_div1", {n_row1, col_r1, col_g1}, exp_q1.pop_front());
        if (exp_q4.size() > 0)
            check("scan_div4", {n_row4, col_r4, col_g4}, exp_q4.pop_front());
        if (started) begin
            checks++;
            if ($countones(~n_row1) > 1 || $countones(~n_row4) > 1) begin
                errors++;
                $display("FAIL one_row_low: got %h/%h expected at most one zero bit", n_row1, n_row4);
            end
        end
    end

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] g_rows[8] = '{8'ha4, 8'he4, 8'hff, 8'he4, 8'he4, 8'hbf, 8'h1e, 8'h3f};
    logic [7:0] n_rows[8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", {n_row1, col_r1, col_g1}, 24'hFF0000);

        // Green scan, two full frames
        pic_r = 64'h0;
        pic_g = 64'ha4e4ffe4e4bf1e3f;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("green_scan", {n_row1, col_r1, col_g1}, {n_rows[i % 8], 8'h00, g_rows[i % 8]});
        end

        // Red/green independence
        pic_r = 64'h0102040810204080;
        pic_g = 64'h8040201008040201;
        do_reset(1);
        @(negedge clk);
        check("indep_row0", {n_row1, col_r1, col_g1}, 24'hFE0180);
        repeat (7) @(negedge clk);
        check("indep_row7", {n_row1, col_r1, col_g1}, 24'h7F8001);

        // Divider on the SCAN_DIV=4 instance
        pic_r = 64'h0;
        pic_g = 64'hFFFFFFFFFFFFFFFF;
        do_reset(1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("div4_hold", {n_row4, col_r4, col_g4}, {(k <= 4) ? 8'hFE : 8'hFD, 8'h00, 8'hFF});
        end
        repeat (24) @(negedge clk);
        check("div4_last_row", {n_row4, col_r4, col_g4}, 24'h7F00FF);
        @(negedge clk);
        check("div4_frame_wrap", {n_row4, col_r4, col_g4}, 24'hFE00FF);

        // Mid-frame reset while row 5 is shown
        pic_g = 64'h0123456789abcdef;
        do_reset(1);
        repeat (6) @(negedge clk);
        check("row5_shown", {n_row1, col_r1, col_g1}, 24'hDF00ab);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset", {n_row1, col_r1, col_g1}, 24'hFF0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_row0", {n_row1, col_r1, col_g1}, 24'hFE0001);

        // Live update while row 2 is shown
        do_reset(1);
        repeat (3) @(negedge clk);
        check("row2_shown", {n_row1, col_r1, col_g1}, 24'hFB0045);
        pic_g = 64'h000000C300000000;
        @(negedge clk);
        check("live_update", {n_row1, col_r1, col_g1}, 24'hF700C3);

        // Random pictures with occasional resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            pic_r = {$urandom, $urandom};
            pic_g = {$urandom, $urandom};
            rst_n = ($urandom_range(0, 40) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 24'(exp_q1.size() + exp_q4.size()), 24'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
